// File: rtl/ysyx_23060042_pkg.sv
// ysyx_23060042_pkg: shared types and constants for the fetch controller
package ysyx_23060042_pkg;
   typedef enum logic [2:0] {BOOT, AR, R_WAIT, HOLD, NEXT, FAULT} fetch_state_e;
   typedef enum logic [1:0] {
      FF_NONE     = 2'b00,
      FF_MISALIGN = 2'b01,
      FF_BUSERR   = 2'b10,
      FF_TIMEOUT  = 2'b11
   } fetch_fault_e;
   localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/ysyx_23060042_fetch_ctrl.sv
// ysyx_23060042_fetch_ctrl: multi-cycle fetch FSM owning the pc, AR/R read channel, decode and npc handshakes
module ysyx_23060042_fetch_ctrl
   import ysyx_23060042_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
   parameter int                TIMEOUT  = 256
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic [ADDR_W-1:0] npc,
   input  logic              npc_valid,
   output logic              npc_ready,
   output logic              fault,
   output logic [1:0]        fault_cause
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   fetch_state_e      state, state_nx;
   fetch_fault_e      cause, cause_nx;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] inst_q;
   logic [CW-1:0]     cnt;
   logic              t_out;
   logic              r_ok;
   assign t_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
   assign r_ok  = rresp == RESP_OKAY;
   // state and sticky fault cause
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= BOOT;
         cause <= FF_NONE;
      end else begin
         state <= state_nx;
         cause <= cause_nx;
      end
   end
   // next state; a beat arriving in the last wait cycle beats the timeout
   always_comb begin
      state_nx = state;
      cause_nx = cause;
      case (state)
         BOOT: begin
            state_nx = pc[1:0] != 2'b00 ? FAULT : AR;
            cause_nx = pc[1:0] != 2'b00 ? FF_MISALIGN : FF_NONE;
         end
         AR: state_nx = arready ? R_WAIT : AR;
         R_WAIT: begin
            if (rvalid) state_nx = r_ok ? HOLD : FAULT;
            else if (t_out) state_nx = FAULT;
            if (rvalid && !r_ok) cause_nx = FF_BUSERR;
            else if (!rvalid && t_out) cause_nx = FF_TIMEOUT;
         end
         HOLD: state_nx = inst_ready ? NEXT : HOLD;
         NEXT: begin
            if (npc_valid) state_nx = npc[1:0] != 2'b00 ? FAULT : AR;
            if (npc_valid && npc[1:0] != 2'b00) cause_nx = FF_MISALIGN;
         end
         default: state_nx = state;
      endcase
   end
   // pc, captured instruction and read-wait counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc     <= RESET_PC;
         inst_q <= '0;
         cnt    <= '0;
      end else begin
         if (state == NEXT && npc_valid) pc <= npc;
         if (state == R_WAIT && rvalid && r_ok) inst_q <= rdata;
         if (state == R_WAIT) cnt <= cnt + CW'(1);
         else if (state == NEXT) cnt <= '0;
      end
   end
   // handshake outputs decoded from state; FAULT keeps rready high to drain late beats
   always_comb begin
      arvalid    = state == AR;
      rready     = state == R_WAIT || state == FAULT;
      inst_valid = state == HOLD;
      npc_ready  = state == NEXT;
      fault      = state == FAULT;
   end
   assign araddr      = pc;
   assign inst_pc     = pc;
   assign inst        = inst_q;
   assign fault_cause = cause;
endmodule

// File: tb/tb_ysyx_23060042_fetch_ctrl.sv
// tb_ysyx_23060042_fetch_ctrl: scoreboard bench with a behavioural memory/decoder model
module tb_ysyx_23060042_fetch_ctrl;
   import ysyx_23060042_pkg::*;
   localparam int          TO  = 16;
   localparam logic [31:0] RPC = 32'h8000_0000;
   logic        clk = 0, rst = 0;
   logic [31:0] araddr, inst, inst_pc;
   logic [31:0] rdata = 0, npc = 0;
   logic [1:0]  rresp = 0, fault_cause;
   logic        arvalid, rready, inst_valid, npc_ready, fault;
   logic        arready = 0, rvalid = 0, inst_ready = 0, npc_valid = 0;
   int          n_cmp = 0, n_err = 0, cyc = 0, rel_cyc = 0;
   int          ar_dly = 0, r_dly = 0, hold_dly = 0, npc_dly = 0;
   int          ar_cnt = 0, r_cnt = 0, h_cnt = 0, n_cnt = 0;
   int          last_ar = 0, last_r = 0, last_npc = 0;
   logic [31:0] npc_next = 0, err_addr = 32'hffff_fff0, rd_addr = 0, pv_araddr = 0;
   logic [63:0] pv_inst = 0;
   logic [1:0]  err_resp = 2'b10, exp_cause = FF_NONE;
   bit          rd_pend = 0, npc_go = 0, junk = 0, chk_lat = 0, fault_seen = 0;
   bit          pv_ar = 0, pv_hold = 0, pv_ihs = 0;
   logic [31:0] addr_q[$];
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   ysyx_23060042_fetch_ctrl #(.TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .npc(npc), .npc_valid(npc_valid), .npc_ready(npc_ready),
      .fault(fault), .fault_cause(fault_cause)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h8000_0013;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: expected event missing or unexpected event", nm);
   endtask

   // reference model: what a fetch of address a must produce
   task automatic push_fetch(input logic [31:0] a);
      if (a[1:0] != 2'b00) exp_cause = FF_MISALIGN;
      else begin
         addr_q.push_back(a);
         if (a == err_addr) exp_cause = FF_BUSERR;
         else if (r_dly >= TO) exp_cause = FF_TIMEOUT;
         else exp_q.push_back({a, mem(a)});
      end
   endtask

   task automatic do_reset(input bit clean);
      @(posedge clk); #1;
      if (clean) chk("queues_drained", {addr_q.size(), exp_q.size()}, 0);
      rst = 0;
      #1;
      chk("reset_outputs", {arvalid, rready, inst_valid, npc_ready, fault, fault_cause, inst, araddr, inst_pc},
          {7'b0, 32'h0, RPC, RPC});
      addr_q.delete();
      exp_q.delete();
      rd_pend = 0; npc_go = 0; fault_seen = 0; exp_cause = FF_NONE;
      repeat (2) @(posedge clk);
      #1;
      push_fetch(RPC);
      rst = 1;
      rel_cyc = cyc + 1;
   endtask

   task automatic wait_next(output bit ok);
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = npc_ready;
      end
      if (!ok) fail("wait_npc_ready");
   endtask

   task automatic step(input logic [31:0] a, input int ad, input int rd, input int hd, input int nd);
      bit ok;
      wait_next(ok);
      ar_dly = ad; r_dly = rd; hold_dly = hd; npc_dly = nd; npc_next = a;
      push_fetch(a);
      npc_go = 1;
      for (int t = 0; t < 50 && npc_go; t++) @(negedge clk);
      if (npc_go) fail("npc_accept");
   endtask

   task automatic wait_fault();
      for (int t = 0; t < 100 && !fault_seen; t++) @(negedge clk);
      if (!fault_seen) fail("fault_rise");
      repeat (4) begin
         @(negedge clk);
         chk("fault_sticky", {fault, inst_valid, npc_ready, arvalid}, 4'b1000);
      end
      err_addr = 32'hffff_fff0;
   endtask

   // memory slave, decoder and execute stand-ins, driven just after the edge
   initial forever begin
      @(posedge clk); #1;
      if (arvalid) begin arready = ar_cnt >= ar_dly; ar_cnt++; end
      else begin arready = 0; ar_cnt = 0; end
      if (rd_pend) begin
         rvalid = r_cnt >= r_dly; r_cnt++;
         rdata = mem(rd_addr);
         rresp = rd_addr == err_addr ? err_resp : RESP_OKAY;
      end else begin
         r_cnt = 0;
         rvalid = junk && $urandom_range(0, 3) == 0;
         rdata = $urandom;
         rresp = 2'($urandom);
      end
      if (inst_valid) begin inst_ready = h_cnt >= hold_dly; h_cnt++; end
      else begin inst_ready = junk && $urandom_range(0, 1) == 1; h_cnt = 0; end
      if (npc_ready && npc_go) begin npc_valid = n_cnt >= npc_dly; npc = npc_next; n_cnt++; end
      else begin
         n_cnt = 0;
         npc_valid = !npc_ready && junk && $urandom_range(0, 1) == 1;
         npc = $urandom;
      end
   end

   // monitor: scoreboard pops and protocol checks on the falling edge
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
         pv_ar = 0; pv_hold = 0; pv_ihs = 0;
      end else begin
         if (fault && !fault_seen) begin
            fault_seen = 1;
            chk("fault_cause", fault_cause, exp_cause);
            chk("fault_time", cyc - (exp_cause == FF_BUSERR ? last_r :
                                     exp_cause == FF_TIMEOUT ? last_ar + TO : last_npc), 1);
         end
         if (pv_ar) chk("ar_stable", {arvalid, araddr}, {1'b1, pv_araddr});
         if (pv_hold) chk("inst_stable", {inst_valid, inst_pc, inst}, {1'b1, pv_inst});
         if (pv_ihs) chk("inst_valid_drop", {inst_valid, npc_ready}, 2'b01);
         if (inst_valid && chk_lat) begin
            chk("first_inst_latency", cyc - rel_cyc, 3);
            chk_lat = 0;
         end
         if (arvalid && arready) begin
            last_ar = cyc; rd_pend = 1; rd_addr = araddr;
            if (addr_q.size() == 0) fail("unexpected_ar");
            else chk("araddr", araddr, addr_q.pop_front());
         end
         if (rvalid && rready) begin rd_pend = 0; last_r = cyc; end
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) fail("unexpected_inst");
            else chk("inst", {inst_pc, inst}, exp_q.pop_front());
         end
         if (npc_valid && npc_ready) begin npc_go = 0; last_npc = cyc; end
         pv_ar = arvalid && !arready; pv_araddr = araddr;
         pv_hold = inst_valid && !inst_ready; pv_inst = {inst_pc, inst};
         pv_ihs = inst_valid && inst_ready;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int kind;
      bit ok, in_rw;
      chk_lat = 1;
      do_reset(0);
      wait_next(ok);
      chk("t1_inst", {inst_pc, inst}, {RPC, 32'h0000_0013});
      step(32'h8000_0004, 5, 3, 0, 0);
      step(32'h8000_0008, 0, 0, 4, 0);
      step(32'h8000_0010, 0, 0, 0, 2);
      step(32'h8000_0014, 0, TO - 1, 0, 0);
      err_addr = 32'h8000_0100;
      step(32'h8000_0100, 1, 2, 0, 0);
      wait_fault();
      r_dly = 0;
      do_reset(1);
      step(32'h8000_0006, 0, 0, 0, 0);
      wait_fault();
      r_dly = 0;
      do_reset(1);
      step(32'h8000_0020, 0, 1000, 0, 0);
      wait_fault();
      r_dly = 0;
      do_reset(1);
      step(32'h8000_0040, 0, 5, 0, 0);
      in_rw = 0;
      for (int t = 0; t < 20 && !in_rw; t++) begin
         @(negedge clk);
         in_rw = rready && !fault;
      end
      if (!in_rw) fail("reach_r_wait");
      #2 rst = 0;
      #1 chk("async_reset", {arvalid, rready, inst_valid, npc_ready, fault, araddr, inst_pc},
             {5'b0, RPC, RPC});
      r_dly = 0;
      chk_lat = 1;
      do_reset(0);
      wait_next(ok);
      chk("refetch_inst", {inst_pc, inst}, {RPC, 32'h0000_0013});
      junk = 1;
      for (int s = 0; s < 4; s++) begin
         r_dly = 0;
         do_reset(1);
         for (int k = 0; k < 12; k++) begin
            a = RPC | (32'($urandom_range(0, 1023)) << 2);
            kind = k == 11 ? int'($urandom_range(0, 5)) : 5;
            if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 1) begin err_addr = a; err_resp = 2'($urandom_range(1, 3)); end
            step(a, $urandom_range(0, 3), kind == 2 ? 1000 : int'($urandom_range(0, 4)),
                 $urandom_range(0, 3), $urandom_range(0, 2));
            if (kind < 3) wait_fault();
         end
         if (!fault_seen) wait_next(ok);
      end
      chk("final_drained", {addr_q.size(), exp_q.size()}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
